// File: rtl/ysyx_24080014_pkg.sv
// Shared encodings for the write-back unit: FSM states, CSR operation codes
// and the machine-mode CSR addresses the WBU is allowed to write.
package ysyx_24080014_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WB         = 2'd1;
    localparam logic [1:0] ST_TRAP_EPC   = 2'd2;
    localparam logic [1:0] ST_TRAP_CAUSE = 2'd3;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'd0,
        CSR_OP_ECALL = 2'd1,
        CSR_OP_MRET  = 2'd2,
        CSR_OP_CSRW  = 2'd3
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // Only the four implemented CSRs may be written; anything else is an error.
    function automatic logic csr_addr_ok(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
               (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/ysyx_24080014_wbu.sv
// Write-back unit: commits one instruction per request, driving the GPR and
// CSR write ports, the next-PC pulse to the IFU and the retire counter.
//
// state         | meaning
// --------------+-------------------------------------------------------
// ST_IDLE       | no latched request, ready to accept
// ST_WB         | perform GPR/CSR write and next-PC for latched request
// ST_TRAP_EPC   | ecall: write mepc <- latched pc
// ST_TRAP_CAUSE | ecall: write mcause <- latched a5, redirect to mtvec
module ysyx_24080014_wbu
    import ysyx_24080014_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic             in_rd_wen,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_rd_data,
    input  logic [1:0]       in_csr_op,
    input  logic [11:0]      in_csr_addr,
    input  logic [31:0]      in_csr_wdata,
    input  logic [31:0]      in_a5,
    input  logic [31:0]      mtvec_val,
    input  logic [31:0]      mepc_val,
    output logic             gpr_wen,
    output logic [4:0]       gpr_waddr,
    output logic [31:0]      gpr_wdata,
    output logic             csr_wen,
    output logic [11:0]      csr_waddr,
    output logic [31:0]      csr_wdata,
    output logic             next_pc_valid,
    output logic [31:0]      next_pc,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             csr_err
);

    logic [1:0]  state;
    logic [31:0] l_pc;
    logic        l_rd_wen;
    logic [4:0]  l_rd;
    logic [31:0] l_rd_data;
    logic [1:0]  l_op;
    logic [11:0] l_csr_addr;
    logic [31:0] l_csr_wdata;
    logic [31:0] l_a5;
    logic        accept;

    // Ready in IDLE, and in WB unless the latched request is an ecall
    // (the trap sequence needs the following two cycles).
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = (state == ST_IDLE) ||
                       ((state == ST_WB) && (l_op != CSR_OP_ECALL));
        end
        accept = in_valid && in_ready;
    end

    // Write ports and next-PC are pure functions of state and latched fields;
    // they are forced low during reset so a mid-trap reset cannot leak a write.
    always_comb begin
        gpr_wen       = 1'b0;
        gpr_waddr     = l_rd;
        gpr_wdata     = l_rd_data;
        csr_wen       = 1'b0;
        csr_waddr     = l_csr_addr;
        csr_wdata     = l_csr_wdata;
        next_pc_valid = 1'b0;
        next_pc       = l_pc + 32'd4;
        if (!rst) begin
            case (state)
                ST_WB: begin
                    gpr_wen = l_rd_wen && (l_rd != 5'd0);
                    if (l_op == CSR_OP_CSRW) begin
                        csr_wen = csr_addr_ok(l_csr_addr);
                    end
                    if (l_op != CSR_OP_ECALL) begin
                        next_pc_valid = 1'b1;
                    end
                    if (l_op == CSR_OP_MRET) begin
                        next_pc = mepc_val;
                    end
                end
                ST_TRAP_EPC: begin
                    csr_wen   = 1'b1;
                    csr_waddr = CSR_MEPC;
                    csr_wdata = l_pc;
                end
                ST_TRAP_CAUSE: begin
                    csr_wen       = 1'b1;
                    csr_waddr     = CSR_MCAUSE;
                    csr_wdata     = l_a5;
                    next_pc_valid = 1'b1;
                    next_pc       = mtvec_val;
                end
                default: ;
            endcase
        end
    end

    // State sequencing, request latching, retire counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            l_pc        <= '0;
            l_rd_wen    <= 1'b0;
            l_rd        <= '0;
            l_rd_data   <= '0;
            l_op        <= '0;
            l_csr_addr  <= '0;
            l_csr_wdata <= '0;
            l_a5        <= '0;
            retire_cnt  <= '0;
            csr_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:       if (accept) state <= ST_WB;
                ST_WB: begin
                    if (l_op == CSR_OP_ECALL) state <= ST_TRAP_EPC;
                    else if (accept)          state <= ST_WB;
                    else                      state <= ST_IDLE;
                end
                ST_TRAP_EPC:   state <= ST_TRAP_CAUSE;
                ST_TRAP_CAUSE: state <= ST_IDLE;
                default:       state <= ST_IDLE;
            endcase
            if (accept) begin
                l_pc        <= in_pc;
                l_rd_wen    <= in_rd_wen;
                l_rd        <= in_rd;
                l_rd_data   <= in_rd_data;
                l_op        <= in_csr_op;
                l_csr_addr  <= in_csr_addr;
                l_csr_wdata <= in_csr_wdata;
                l_a5        <= in_a5;
            end
            if ((state == ST_WB) && (l_op == CSR_OP_CSRW) && !csr_addr_ok(l_csr_addr)) begin
                csr_err <= 1'b1;
            end
            retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, next_pc_valid};
        end
    end

endmodule

// File: tb/tb_ysyx_24080014_wbu.sv
// Directed bench for the write-back unit with hand-computed expectations.
module tb_ysyx_24080014_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic        in_rd_wen;
    logic [4:0]  in_rd;
    logic [31:0] in_rd_data;
    logic [1:0]  in_csr_op;
    logic [11:0] in_csr_addr;
    logic [31:0] in_csr_wdata;
    logic [31:0] in_a5;
    logic [31:0] mtvec_val;
    logic [31:0] mepc_val;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        next_pc_valid;
    logic [31:0] next_pc;
    logic [31:0] retire_cnt;
    logic        csr_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_24080014_wbu #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rd_wen(in_rd_wen), .in_rd(in_rd), .in_rd_data(in_rd_data),
        .in_csr_op(in_csr_op), .in_csr_addr(in_csr_addr), .in_csr_wdata(in_csr_wdata),
        .in_a5(in_a5), .mtvec_val(mtvec_val), .mepc_val(mepc_val),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .next_pc_valid(next_pc_valid), .next_pc(next_pc),
        .retire_cnt(retire_cnt), .csr_err(csr_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic wen,
                         input logic [4:0] rd, input logic [31:0] data, input logic [1:0] op,
                         input logic [11:0] caddr, input logic [31:0] cdata, input logic [31:0] a5);
        in_valid = v; in_pc = pc; in_rd_wen = wen; in_rd = rd; in_rd_data = data;
        in_csr_op = op; in_csr_addr = caddr; in_csr_wdata = cdata; in_a5 = a5;
        #1;
    endtask

    task automatic idle_in();
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 2'd0, 12'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; mtvec_val = 32'h8000_1000; mepc_val = 32'h0;
        idle_in();
        check("ready_in_rst", in_ready, 0);
        tick(); tick();
        rst = 1'b0; #1;
        check("rst_ready", in_ready, 1);
        check("rst_gpr_wen", gpr_wen, 0);
        check("rst_npv", next_pc_valid, 0);
        check("rst_retire", retire_cnt, 0);
        check("rst_csr_err", csr_err, 0);

        // addi x5 = 0x11
        drive(1, 32'h8000_0000, 1, 5'd5, 32'h11, 2'd0, 12'h0, 32'h0, 32'h0);
        tick(); idle_in();
        check("addi_gpr_wen", gpr_wen, 1);
        check("addi_waddr", gpr_waddr, 5);
        check("addi_wdata", gpr_wdata, 32'h11);
        check("addi_npv", next_pc_valid, 1);
        check("addi_next_pc", next_pc, 32'h8000_0004);
        check("addi_csr_wen", csr_wen, 0);
        tick();
        check("addi_retire", retire_cnt, 1);
        check("addi_idle_npv", next_pc_valid, 0);
        check("addi_idle_gpr", gpr_wen, 0);

        // rd = 0 must not write
        drive(1, 32'h8000_0004, 1, 5'd0, 32'hDEAD, 2'd0, 12'h0, 32'h0, 32'h0);
        tick(); idle_in();
        check("x0_gpr_wen", gpr_wen, 0);
        check("x0_npv", next_pc_valid, 1);
        check("x0_next_pc", next_pc, 32'h8000_0008);
        tick();
        check("x0_retire", retire_cnt, 2);

        // ecall
        drive(1, 32'h8000_0010, 0, 5'd0, 32'h0, 2'd1, 12'h0, 32'h0, 32'hB);
        tick(); idle_in();
        check("ecall_wb_ready", in_ready, 0);
        check("ecall_wb_npv", next_pc_valid, 0);
        check("ecall_wb_csr_wen", csr_wen, 0);
        tick();
        check("ecall_epc_ready", in_ready, 0);
        check("ecall_epc_wen", csr_wen, 1);
        check("ecall_epc_addr", csr_waddr, 32'h341);
        check("ecall_epc_data", csr_wdata, 32'h8000_0010);
        check("ecall_epc_npv", next_pc_valid, 0);
        tick();
        check("ecall_cause_ready", in_ready, 0);
        check("ecall_cause_wen", csr_wen, 1);
        check("ecall_cause_addr", csr_waddr, 32'h342);
        check("ecall_cause_data", csr_wdata, 32'hB);
        check("ecall_cause_npv", next_pc_valid, 1);
        check("ecall_cause_pc", next_pc, 32'h8000_1000);
        tick();
        check("ecall_done_ready", in_ready, 1);
        check("ecall_done_wen", csr_wen, 0);
        check("ecall_retire", retire_cnt, 3);

        // mret
        mepc_val = 32'h8000_0014;
        drive(1, 32'h8000_1000, 0, 5'd0, 32'h0, 2'd2, 12'h0, 32'h0, 32'h0);
        tick(); idle_in();
        check("mret_npv", next_pc_valid, 1);
        check("mret_pc", next_pc, 32'h8000_0014);
        check("mret_csr_wen", csr_wen, 0);
        tick();
        check("mret_single", next_pc_valid, 0);
        check("mret_retire", retire_cnt, 4);

        // csrw to mtvec plus GPR write in the same cycle
        drive(1, 32'h8000_0020, 1, 5'd7, 32'h55, 2'd3, 12'h305, 32'h8000_2000, 32'h0);
        tick(); idle_in();
        check("csrw_wen", csr_wen, 1);
        check("csrw_addr", csr_waddr, 32'h305);
        check("csrw_data", csr_wdata, 32'h8000_2000);
        check("csrw_gpr_wen", gpr_wen, 1);
        check("csrw_next_pc", next_pc, 32'h8000_0024);
        tick();
        check("csrw_err", csr_err, 0);
        check("csrw_retire", retire_cnt, 5);

        // csrw to unimplemented CSR
        drive(1, 32'h8000_0024, 0, 5'd0, 32'h0, 2'd3, 12'h7C0, 32'h1234, 32'h0);
        tick(); idle_in();
        check("bad_csr_wen", csr_wen, 0);
        check("bad_csr_npv", next_pc_valid, 1);
        tick();
        check("bad_csr_err", csr_err, 1);
        check("bad_csr_retire", retire_cnt, 6);

        // three back-to-back requests
        drive(1, 32'h0000_0100, 0, 5'd0, 32'h0, 2'd0, 12'h0, 32'h0, 32'h0);
        tick();
        drive(1, 32'h0000_0200, 0, 5'd0, 32'h0, 2'd0, 12'h0, 32'h0, 32'h0);
        check("b2b_ready", in_ready, 1);
        check("b2b_npv0", next_pc_valid, 1);
        check("b2b_pc0", next_pc, 32'h104);
        tick();
        drive(1, 32'h0000_0300, 0, 5'd0, 32'h0, 2'd0, 12'h0, 32'h0, 32'h0);
        check("b2b_npv1", next_pc_valid, 1);
        check("b2b_pc1", next_pc, 32'h204);
        tick(); idle_in();
        check("b2b_npv2", next_pc_valid, 1);
        check("b2b_pc2", next_pc, 32'h304);
        tick();
        check("b2b_end_npv", next_pc_valid, 0);
        check("b2b_retire", retire_cnt, 9);
        check("b2b_err_sticky", csr_err, 1);

        // reset in the middle of a trap
        drive(1, 32'h8000_0030, 0, 5'd0, 32'h0, 2'd1, 12'h0, 32'h0, 32'h8);
        tick(); idle_in();
        tick();
        check("mid_epc_wen", csr_wen, 1);
        check("mid_epc_addr", csr_waddr, 32'h341);
        rst = 1'b1; #1;
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_csr_wen", csr_wen, 0);
        tick();
        rst = 1'b0; #1;
        check("post_rst_csr_wen", csr_wen, 0);
        check("post_rst_npv", next_pc_valid, 0);
        check("post_rst_retire", retire_cnt, 0);
        check("post_rst_err", csr_err, 0);
        check("post_rst_ready", in_ready, 1);
        tick();
        check("post_rst_no_cause", csr_wen, 0);
        check("post_rst_no_npv", next_pc_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
